// File: rtl/ext_arb_pkg.sv
// Shared types and constants for the two-requester external memory arbiter.
package ext_arb_pkg;

    // Arbiter transaction sequencing
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

    // Kind of request held in a slot
    typedef enum logic {
        REQ_RD = 1'b0,
        REQ_WR = 1'b1
    } req_type_e;

    // Response encoding: bit0 done, bit1 error
    localparam logic [1:0] RESP_NONE = 2'b00;
    localparam logic [1:0] RESP_OK   = 2'b01;
    localparam logic [1:0] RESP_ERR  = 2'b11;

endpackage

// File: rtl/ext_arb_req_slot.sv
// One-deep request buffer for a single requester; flags protocol violations.
module ext_arb_req_slot
    import ext_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 20,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              awvalid,
    input  logic              wvalid,
    input  logic              arvalid,
    input  logic              clr,
    output logic              pending,
    output req_type_e         req_type,
    output logic [ADDR_W-1:0] addr_q,
    output logic [DATA_W-1:0] wdata_q,
    output logic              ovf
);

    logic any_c;
    logic viol_c;
    logic cap_c;

    // Classify the request pulse: capture into an empty slot, otherwise drop and flag
    always_comb begin
        any_c  = awvalid | wvalid | arvalid;
        viol_c = any_c & (pending | (awvalid ^ wvalid) | ((awvalid | wvalid) & arvalid));
        cap_c  = any_c & ~viol_c;
    end

    // Slot contents and sticky violation flag
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pending  <= 1'b0;
            req_type <= REQ_RD;
            addr_q   <= '0;
            wdata_q  <= '0;
            ovf      <= 1'b0;
        end else begin
            if (clr) begin
                pending <= 1'b0;
            end else if (cap_c) begin
                pending  <= 1'b1;
                req_type <= (awvalid) ? REQ_WR : REQ_RD;
                addr_q   <= data_addr;
                wdata_q  <= (awvalid) ? wdata : '0;
            end
            if (viol_c) begin
                ovf <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ext_mem_arbiter.sv
// Round-robin arbiter sharing one external memory port between two cache controllers.
// Optional watchdog on the memory response is enabled by defining ARB_TIMEOUT_EN.
module ext_mem_arbiter
    import ext_arb_pkg::*;
#(
    parameter int unsigned ADDR_W      = 20,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [ADDR_W-1:0] r0_data_addr,
    input  logic [ADDR_W-1:0] r1_data_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    input  logic [DATA_W-1:0] r1_wdata,
    input  logic              r0_awvalid,
    input  logic              r0_wvalid,
    input  logic              r1_awvalid,
    input  logic              r1_wvalid,
    input  logic              r0_arvalid,
    input  logic              r1_arvalid,
    output logic              r0_rvalid,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] r0_rdata,
    output logic [DATA_W-1:0] r1_rdata,
    output logic [1:0]        r0_w_resp,
    output logic [1:0]        r1_w_resp,
    output logic [1:0]        r0_r_resp,
    output logic [1:0]        r1_r_resp,
    output logic              r0_busy,
    output logic              r1_busy,
    output logic              r0_ovf,
    output logic              r1_ovf,
    output logic [ADDR_W-1:0] ext_data_addr,
    output logic [DATA_W-1:0] ext_wdata,
    output logic              ext_awvalid,
    output logic              ext_wvalid,
    output logic              ext_arvalid,
    input  logic              ext_rvalid,
    input  logic [DATA_W-1:0] ext_rdata,
    input  logic [1:0]        ext_w_resp,
    input  logic [1:0]        ext_r_resp
);

    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 1");
    end

    // Slot interface
    logic              pend     [2];
    req_type_e         rtype    [2];
    logic [ADDR_W-1:0] saddr    [2];
    logic [DATA_W-1:0] swdata   [2];
    logic              sovf     [2];
    logic              clr_c    [2];

    // Arbiter state
    arb_state_e state_q, state_d;
    logic       gnt_q, gnt_d;
    logic       last_q, last_d;
    req_type_e  gtype_q, gtype_d;
    logic       sel_c;

    // Registered outputs and their next values
    logic [ADDR_W-1:0] ext_addr_d;
    logic [DATA_W-1:0] ext_wdata_d;
    logic              ext_awvalid_d, ext_wvalid_d, ext_arvalid_d;
    logic [1:0]        wresp_q  [2], wresp_d  [2];
    logic [1:0]        rresp_q  [2], rresp_d  [2];
    logic              rvalid_q [2], rvalid_d [2];
    logic [DATA_W-1:0] rdata_q  [2], rdata_d  [2];

    // Read data is qualified by ext_r_resp[0]; ext_rvalid carries no extra information
    logic unused_ext_rvalid;
    assign unused_ext_rvalid = ext_rvalid;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMR_W-1:0] tmr_q, tmr_d;
`endif

    ext_arb_req_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot0 (
        .clk       (clk),
        .rstn      (rstn),
        .data_addr (r0_data_addr),
        .wdata     (r0_wdata),
        .awvalid   (r0_awvalid),
        .wvalid    (r0_wvalid),
        .arvalid   (r0_arvalid),
        .clr       (clr_c[0]),
        .pending   (pend[0]),
        .req_type  (rtype[0]),
        .addr_q    (saddr[0]),
        .wdata_q   (swdata[0]),
        .ovf       (sovf[0])
    );

    ext_arb_req_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot1 (
        .clk       (clk),
        .rstn      (rstn),
        .data_addr (r1_data_addr),
        .wdata     (r1_wdata),
        .awvalid   (r1_awvalid),
        .wvalid    (r1_wvalid),
        .arvalid   (r1_arvalid),
        .clr       (clr_c[1]),
        .pending   (pend[1]),
        .req_type  (rtype[1]),
        .addr_q    (saddr[1]),
        .wdata_q   (swdata[1]),
        .ovf       (sovf[1])
    );

    // Next-state and next-output logic; pulsed outputs default to zero every cycle
    always_comb begin
        state_d       = state_q;
        gnt_d         = gnt_q;
        last_d        = last_q;
        gtype_d       = gtype_q;
        sel_c         = 1'b0;
        ext_addr_d    = '0;
        ext_wdata_d   = '0;
        ext_awvalid_d = 1'b0;
        ext_wvalid_d  = 1'b0;
        ext_arvalid_d = 1'b0;
        for (int i = 0; i < 2; i++) begin
            wresp_d[i]  = RESP_NONE;
            rresp_d[i]  = RESP_NONE;
            rvalid_d[i] = 1'b0;
            rdata_d[i]  = '0;
            clr_c[i]    = 1'b0;
        end
`ifdef ARB_TIMEOUT_EN
        tmr_d = '0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (pend[0] | pend[1]) begin
                    sel_c       = (pend[0] & pend[1]) ? ~last_q : pend[1];
                    gnt_d       = sel_c;
                    gtype_d     = rtype[sel_c];
                    ext_addr_d  = saddr[sel_c];
                    if (rtype[sel_c] == REQ_WR) begin
                        ext_wdata_d   = swdata[sel_c];
                        ext_awvalid_d = 1'b1;
                        ext_wvalid_d  = 1'b1;
                    end else begin
                        ext_arvalid_d = 1'b1;
                    end
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (gtype_q == REQ_WR && ext_w_resp[0]) begin
                    wresp_d[gnt_q] = ext_w_resp;
                    state_d        = ST_RESP;
                end else if (gtype_q == REQ_RD && ext_r_resp[0]) begin
                    rresp_d[gnt_q]  = ext_r_resp;
                    rvalid_d[gnt_q] = 1'b1;
                    rdata_d[gnt_q]  = ext_rdata;
                    state_d         = ST_RESP;
                end
`ifdef ARB_TIMEOUT_EN
                else if (tmr_q == TMR_W'(TIMEOUT_CYC - 1)) begin
                    if (gtype_q == REQ_WR) begin
                        wresp_d[gnt_q] = RESP_ERR;
                    end else begin
                        rresp_d[gnt_q]  = RESP_ERR;
                        rvalid_d[gnt_q] = 1'b1;
                    end
                    state_d = ST_RESP;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
`endif
            end
            ST_RESP: begin
                clr_c[gnt_q] = 1'b1;
                last_d       = gnt_q;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= ST_IDLE;
            gnt_q         <= 1'b0;
            last_q        <= 1'b1;
            gtype_q       <= REQ_RD;
            ext_data_addr <= '0;
            ext_wdata     <= '0;
            ext_awvalid   <= 1'b0;
            ext_wvalid    <= 1'b0;
            ext_arvalid   <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                wresp_q[i]  <= RESP_NONE;
                rresp_q[i]  <= RESP_NONE;
                rvalid_q[i] <= 1'b0;
                rdata_q[i]  <= '0;
            end
`ifdef ARB_TIMEOUT_EN
            tmr_q <= '0;
`endif
        end else begin
            state_q       <= state_d;
            gnt_q         <= gnt_d;
            last_q        <= last_d;
            gtype_q       <= gtype_d;
            ext_data_addr <= ext_addr_d;
            ext_wdata     <= ext_wdata_d;
            ext_awvalid   <= ext_awvalid_d;
            ext_wvalid    <= ext_wvalid_d;
            ext_arvalid   <= ext_arvalid_d;
            for (int i = 0; i < 2; i++) begin
                wresp_q[i]  <= wresp_d[i];
                rresp_q[i]  <= rresp_d[i];
                rvalid_q[i] <= rvalid_d[i];
                rdata_q[i]  <= rdata_d[i];
            end
`ifdef ARB_TIMEOUT_EN
            tmr_q <= tmr_d;
`endif
        end
    end

    assign r0_rvalid = rvalid_q[0];
    assign r1_rvalid = rvalid_q[1];
    assign r0_rdata  = rdata_q[0];
    assign r1_rdata  = rdata_q[1];
    assign r0_w_resp = wresp_q[0];
    assign r1_w_resp = wresp_q[1];
    assign r0_r_resp = rresp_q[0];
    assign r1_r_resp = rresp_q[1];
    assign r0_busy   = pend[0];
    assign r1_busy   = pend[1];
    assign r0_ovf    = sovf[0];
    assign r1_ovf    = sovf[1];

endmodule

// File: doc/ext_mem_arbiter.md
# ext_mem_arbiter

Two-requester arbiter sharing one external memory port between two `mesi_coherency` cache controllers. It sits between the caches' `ext_*` master ports and the single `external_memory` instance. Each requester gets a one-deep request slot. Grants are round-robin, one memory transaction is in flight at a time, and the response is routed back to the owner.

## Interface
- `ADDR_W`, 20, address width
- `DATA_W`, 32, data width
- `TIMEOUT_CYC`, 1024, watchdog limit in cycles; used only with `ARB_TIMEOUT_EN`

- `clk` in 1: single clock; all logic on posedge.
- `rstn` in 1: reset, asynchronous, active-low.
- `r0_data_addr`, `r1_data_addr` in ADDR_W: request address.
- `r0_wdata`, `r1_wdata` in DATA_W: write data.
- `r0_awvalid`/`r0_wvalid`, `r1_awvalid`/`r1_wvalid` in 1: write request; both asserted the same cycle.
- `r0_arvalid`, `r1_arvalid` in 1: read request.
- `r0_rvalid`, `r1_rvalid` out 1: read data valid.
- `r0_rdata`, `r1_rdata` out DATA_W: read data.
- `r0_w_resp`, `r1_w_resp`, `r0_r_resp`, `r1_r_resp` out 2: bit0 done, bit1 error.
- `r0_busy`, `r1_busy` out 1: the requester's slot holds a request.
- `r0_ovf`, `r1_ovf` out 1: sticky protocol-violation flag.
- `ext_data_addr` out ADDR_W, `ext_wdata` out DATA_W, `ext_awvalid`/`ext_wvalid`/`ext_arvalid` out 1: memory master side.
- `ext_rvalid` in 1, `ext_rdata` in DATA_W, `ext_w_resp`/`ext_r_resp` in 2: memory response side.

## Operation
- **Capture.** Requests are single-cycle pulses.
  - `awvalid&wvalid` latches a write (addr, data).
  - `arvalid` alone latches a read.
  - Capture happens only when the slot is empty; `busy` rises the next cycle.
- **Violations.** Each sets `ovf` and the request is dropped:
  - a request while `busy`;
  - `awvalid` without `wvalid` (or the reverse);
  - write and read in the same cycle.
- **FSM** `IDLE -> ISSUE -> WAIT -> RESP -> IDLE`:
  - **IDLE.** If any slot is pending, grant it and go to ISSUE. If both are pending, grant the requester not granted last (`last_grant` resets to 1, so r0 wins the first tie).
  - **ISSUE.** For exactly one cycle drive `ext_data_addr`, plus `ext_awvalid`+`ext_wvalid`+`ext_wdata` for a write or `ext_arvalid` for a read. Go to WAIT.
  - **WAIT.** Hold until `ext_w_resp[0]` (write) or `ext_r_resp[0]` (read). Latch the resp value and `ext_rdata`, then go to RESP.
  - **RESP.** Pulse the granted requester's matching `*_resp` for one cycle with the latched value. For reads, also pulse `rvalid` and drive `rdata` the same cycle. Clear the slot, update `last_grant`, return to IDLE.
- **Ignored inputs.** Memory responses outside WAIT, and of the wrong type in WAIT, are ignored.
- **Slot refill.** A requester may re-request in the cycle after its resp pulse (slot clear).

## Timing
- **Reset values.** All outputs are 0, FSM is IDLE, slots are empty, `ovf` is cleared, `last_grant` is 1.
- **Ext outputs.** `ext_*` outputs are registered; valids are high only in ISSUE.
- **Latency.** For a request pulse in cycle T with memory response L cycles after ISSUE:
  - ISSUE occurs at T+2;
  - resp pulse occurs at T+3+L when uncontended.
- **Contended request.** It waits for the full in-flight transaction plus one IDLE cycle.
- **Reset mid-transaction.** The in-flight transaction is abandoned with no response to the requester. `ext_*` valids drop asynchronously.
- **Error propagation.** An error response (bit1) from memory is forwarded unchanged.

## Configuration
- **`ARB_TIMEOUT_EN` defined.**
  - A cycle counter runs in WAIT.
  - After `TIMEOUT_CYC` cycles without a response, go to RESP with resp `2'b11` and `rdata` = 0.
  - A late memory response is then ignored.
- **Not defined.** WAIT holds indefinitely; no counter is present.

## Structure
- **Package `ext_arb_pkg`.**
  - FSM state enum.
  - `RESP_OK` = 2'b01 and `RESP_ERR` = 2'b11.
  - Request-type encoding (`REQ_RD`, `REQ_WR`).
- **Sub-module `ext_arb_req_slot`.**
  - Per-requester capture buffer: pending, type, addr, wdata, `ovf`.
  - Instantiated twice; clear input driven in RESP.

## Test plan
- r0 write 0x00010 := 0xDEADBEEF, memory latency 3 -> `ext_awvalid` at T+2; `r0_w_resp`=01 at T+6; `r1_*` stays 0.
- r0 and r1 read in the same cycle -> r0 is served first, then r1; next simultaneous pair is served r1 first (round-robin alternation).
- r0 read of 0x00040 after a write of 0x1234 there -> `r0_rvalid` pulse with `r0_rdata`=0x1234, `r0_r_resp`=01.
- r1 issues a second read while `r1_busy` -> `r1_ovf`=1, exactly one transaction on `ext_*`.
- `ARB_TIMEOUT_EN`, `TIMEOUT_CYC`=8, memory never responds -> `r0_r_resp`=11, `r0_rdata`=0 eight cycles into WAIT.
- `rstn` pulled low during WAIT -> all outputs 0, FSM in IDLE, no resp pulse; a new request after reset completes normally.
